// File: rtl/sync_fifo_reader.sv
// Read-side controller for a synchronous FIFO with 1-cycle read latency.
// Captures FIFO words into a small holding buffer and presents them as a valid/ready stream.
module sync_fifo_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BUF_DEPTH  = 2,  // legal range 2..4
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  idle
);

  localparam int unsigned OccW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PtrW = $clog2(BUF_DEPTH);

  // One extra bit so occ + inflight can be compared against the depth without overflow.
  localparam logic [OccW:0]   DepthExt = (OccW + 1)'(BUF_DEPTH);
  localparam logic [PtrW-1:0] PtrLast  = PtrW'(BUF_DEPTH - 1);

  logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];

  logic [OccW-1:0]      occ_q, occ_d;
  logic                 inflight_q, inflight_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                 pop;
  logic [OccW:0]        occ_sum;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  assign m_valid = (occ_q != '0);
  assign pop     = m_valid && m_ready;

  // pop >= 1 only when occ >= 1, so this never goes negative.
  assign occ_sum = {1'b0, occ_q} + (OccW + 1)'(inflight_q) - (OccW + 1)'(pop);

  // Combinational m_ready -> fifo_rd_en path keeps a depth-2 buffer streaming at 1 word/clk.
  assign fifo_rd_en = !rst && en && !fifo_empty && (occ_sum < DepthExt);

  assign m_data   = m_valid ? buf_q[rd_ptr_q] : '0;
  assign rd_count = cnt_q;
  assign idle     = !m_valid && !inflight_q && fifo_empty;

  always_comb begin
    occ_d      = occ_sum[OccW-1:0];
    inflight_d = fifo_rd_en;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    if (inflight_q) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Storage needs no reset: m_data is masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (!rst && inflight_q) begin
      buf_q[wr_ptr_q] <= fifo_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (occ_sum <= DepthExt);
      assert ({1'b0, occ_q} <= DepthExt);
    end
  end

endmodule
